car_sensor_conditioner: RTL

CAR_SENSOR_CONDITIONER -- requirements
Module: car_sensor_conditioner

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/car_sensor_conditioner.sv | 112 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: types shared between the country-road sensor conditioner
// and the traffic_signal controller.
//   lamp_t         - country-road lamp encoding fed back from traffic_signal
//   sensor_state_t - debounce FSM state of the loop-detector conditioner
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } lamp_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        RISE_CHK = 2'd1,
        OCCUPIED = 2'd2,
        FALL_CHK = 2'd3
    } sensor_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, clears both flops
//   d_i    - asynchronous input
//   q_o    - synchronized output (second flop)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: debounces the country-road loop detector, counts
// waiting cars and raises the car-waiting request for traffic_signal.
//   clk               - rising-edge clock
//   reset             - synchronous active-high reset
//   sensor_raw        - asynchronous bouncy loop detector (1 = metal present)
//   cntry_road_signal - country-road lamp state (lamp_t encoding)
//   x                 - car-waiting request, (car_count != 0)
//   car_count         - arrivals not yet served, saturating at MAX_COUNT
//   sensor_clean      - debounced occupancy
//   state_out         - debounce FSM state, for debug
module car_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,   // 1..255
    parameter int MAX_COUNT       = 15   // 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_raw,
    input  logic [1:0] cntry_road_signal,
    output logic       x,
    output logic [3:0] car_count,
    output logic       sensor_clean,
    output logic [1:0] state_out
);

    localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CYCLES);
    localparam logic [3:0] CNT_MAX = 4'(MAX_COUNT);

    logic          s_sync;
    sensor_state_t state_q, state_d;
    logic [7:0]    deb_cnt_q, deb_cnt_d;
    logic [3:0]    count_q, count_d;
    logic          arrival;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sensor_raw),
        .q_o   (s_sync)
    );

    // Debounce FSM. deb_cnt counts consecutive stable samples seen in a
    // check state, starting at 1 on the sample that triggered the check.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        arrival   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (s_sync) begin
                    state_d   = RISE_CHK;
                    deb_cnt_d = 8'd1;
                end
            end
            RISE_CHK: begin
                if (!s_sync) begin
                    state_d = EMPTY;
                end else if (deb_cnt_q == DEB_LIM) begin
                    state_d = OCCUPIED;
                    arrival = 1'b1;   // the only place a car is counted
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            OCCUPIED: begin
                if (!s_sync) begin
                    state_d   = FALL_CHK;
                    deb_cnt_d = 8'd1;
                end
            end
            FALL_CHK: begin
                if (s_sync) begin
                    state_d = OCCUPIED;
                end else if (deb_cnt_q == DEB_LIM) begin
                    state_d = EMPTY;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Green wins over a same-cycle arrival: that car drives straight through.
    always_comb begin
        count_d = count_q;
        if (cntry_road_signal == GREEN) begin
            count_d = 4'd0;
        end else if (arrival && (count_q != CNT_MAX)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            deb_cnt_q <= 8'd0;
            count_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            count_q   <= count_d;
        end
    end

    assign car_count    = count_q;
    assign x            = (count_q != 4'd0);
    assign sensor_clean = (state_q == OCCUPIED) || (state_q == FALL_CHK);
    assign state_out    = state_q;

endmodule
